irq_dispatch_seq: RTL
=====================

# irq_dispatch_seq

Sequencer that turns pending interrupt requests into a CPU interrupt entry. It owns the IME flag, the EI one-instruction delay, HALT wake-up, and the 5 M-cycle dispatch sequence: two internal cycles, push PCH, push PCL, then load PC with the vector. It sits between the IE/IF request logic and the instruction decoder/sequencer, and drives stack-push and PC-load strobes into the datapath.

## Interface
- NUM_IRQ, 5, number of request lines; bit 0 has the highest priority.
- VEC_BASE, 8'h40, vector of request 0.
- VEC_STRIDE, 8, vector spacing in bytes.
- CLK  in  1  system clock; all state updates occur on the rising edge.
- nRESET  in  1  reset, asynchronous and active-low.
- MCYCLE  in  1  one-CLK strobe per machine cycle; the FSM, IME and HALT logic advance only when it is 1.
- PEND  in  NUM_IRQ  IE & IF per line.
- BOUNDARY  in  1  decoder is at an opcode-fetch point; sampled with MCYCLE.
- EI_STB, DI_STB, RETI_STB, HALT_STB  in  1 each  decoder strobes, each qualified with MCYCLE.
- IME  out  1  interrupt master enable.
- HALTED  out  1  CPU halted.
- HALT_BUG  out  1  one-MCYCLE pulse: HALT executed with IME=0 while a request was already pending.
- BUSY  out  1  dispatch in progress; the decoder stalls while it is 1.
- PUSH_HI, PUSH_LO  out  1 each  SP-decrement-and-write strobes for PCH / PCL.
- LOAD_PC  out  1  PC <= VECTOR.
- VECTOR  out  16  dispatch target.
- IF_CLR  out  NUM_IRQ  one-hot clear of the serviced IF bit.

## Operation
- The priority encoder returns the lowest set index of PEND; `any` = |PEND.
- FSM states: IDLE, WAIT1, WAIT2, PUSH_HI, PUSH_LO, JUMP.
  - IDLE -> WAIT1 on MCYCLE & BOUNDARY & IME & any.
  - After that, each MCYCLE advances one state; JUMP -> IDLE.
- Entering WAIT1 clears IME and cancels any pending EI.
- Vector resolution happens at the MCYCLE that ends PUSH_HI, using the PEND value at that instant:
  - pending: VECTOR = {8'h00, VEC_BASE + VEC_STRIDE*idx} and the index is latched;
  - nothing pending (request withdrawn during the push): VECTOR = 16'h0000 and no IF clear.
- JUMP state: LOAD_PC = 1 and IF_CLR = one-hot(latched idx), or 0 if the dispatch was cancelled.
- PUSH_HI and PUSH_LO are 1 exactly during their states. BUSY is 1 in every state except IDLE.
- EI sets ei_pend. IME becomes 1 at the next MCYCLE & BOUNDARY after that, i.e. after one more instruction. The dispatch decision made in that same cycle uses the old IME (0).
- DI clears IME and ei_pend immediately. RETI sets IME immediately. EI while IME=1 has no effect.
- HALT_STB:
  - if IME=0 and any: HALT_BUG pulses, HALTED stays 0;
  - otherwise HALTED is set.
- HALTED clears at any MCYCLE with any=1, regardless of IME. Dispatch follows at the next BOUNDARY if IME=1.
- Simultaneous events:
  - DI and EI in the same MCYCLE: DI wins.
  - Dispatch start and DI at the same boundary: dispatch proceeds, IME stays 0.
  - Strobes received while BUSY are ignored.

## Timing
- All outputs are registered.
- Reset values: IME 0, HALTED 0, HALT_BUG 0, BUSY 0, PUSH_HI 0, PUSH_LO 0, LOAD_PC 0, VECTOR 16'h0000, IF_CLR 0, FSM IDLE, ei_pend 0.
- Dispatch takes exactly 5 M-cycles from the qualifying boundary to the end of JUMP.
  - PUSH_HI is high in M-cycle 3, PUSH_LO in M-cycle 4, LOAD_PC in M-cycle 5.
- The EI delay is one full instruction, measured in BOUNDARY strobes.
- Wake from HALT: HALTED falls 1 MCYCLE after PEND rises.
- Asserting nRESET mid-dispatch aborts immediately: all outputs return to reset values with no partial IF clear. Sequencing resumes on the first MCYCLE after release.
- PEND changes between MCYCLE strobes are ignored.

## Structure
- Shared package irq_pkg holds:
  - the state enum typedef (6 states);
  - localparams NUM_IRQ, VEC_BASE, VEC_STRIDE, and M_DISPATCH = 5.
- One sub-module, irq_prio_enc: combinational, PEND -> {any, idx, onehot}. It is reused for both the vector and IF_CLR.

## Test plan
- IME=1, PEND=5'b00100 at BOUNDARY -> PUSH_HI at M3, PUSH_LO at M4, LOAD_PC at M5, VECTOR=16'h0050, IF_CLR=5'b00100, IME=0.
- PEND=5'b10011 -> VECTOR=16'h0040, IF_CLR=5'b00001; after a second boundary with IME restored, VECTOR=16'h0048.
- PEND cleared during PUSH_HI -> VECTOR=16'h0000, IF_CLR=0, LOAD_PC still pulses.
- EI, then PEND=1 at the next boundary -> no dispatch there; dispatch starts at the following boundary.
- HALT with IME=0 and PEND=0, then PEND=5'b01000 -> HALTED falls next MCYCLE with no dispatch. HALT with IME=0 and PEND already set -> HALT_BUG pulse, HALTED stays 0.
- nRESET low during PUSH_LO -> all outputs go to reset values asynchronously, IME=0, no IF_CLR.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt dispatch sequencer.
// Vector helper maps a request index to its entry address.
package irq_pkg;

    localparam int NUM_IRQ = 5;
    localparam int IDX_W = $clog2(NUM_IRQ);
    localparam logic [7:0] VEC_BASE = 8'h40;
    localparam logic [7:0] VEC_STRIDE = 8'd8;
    localparam int M_DISPATCH = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT1,
        ST_WAIT2,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_JUMP
    } irq_state_e;

    function automatic logic [15:0] vec_of(input logic [IDX_W-1:0] idx);
        logic [7:0] off;
        off = VEC_STRIDE * 8'(idx);
        return {8'h00, VEC_BASE + off};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over pending requests; bit 0 wins.
// Produces the any flag, the winning index and its one-hot form.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] pend,
    output logic               any,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_IRQ-1:0] onehot
);

    always_comb begin
        any = |pend;
        idx = '0;
        onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = IDX_W'(i);
                onehot = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_dispatch_seq.sv
// Interrupt entry sequencer: IME/EI delay, HALT wake-up and the
// five M-cycle dispatch (two waits, push PCH, push PCL, jump).
module irq_dispatch_seq
    import irq_pkg::*;
(
    input  logic               CLK,
    input  logic               nRESET,
    input  logic               MCYCLE,
    input  logic [NUM_IRQ-1:0] PEND,
    input  logic               BOUNDARY,
    input  logic               EI_STB,
    input  logic               DI_STB,
    input  logic               RETI_STB,
    input  logic               HALT_STB,
    output logic               IME,
    output logic               HALTED,
    output logic               HALT_BUG,
    output logic               BUSY,
    output logic               PUSH_HI,
    output logic               PUSH_LO,
    output logic               LOAD_PC,
    output logic [15:0]        VECTOR,
    output logic [NUM_IRQ-1:0] IF_CLR
);

    irq_state_e state, state_nxt;

    logic               ime_q, ime_nxt;
    logic               ei_pend, ei_nxt;
    logic               halted_q, halted_nxt;
    logic               bug_q, bug_nxt;
    logic [15:0]        vec_q, vec_nxt;
    logic [NUM_IRQ-1:0] sel_q, sel_nxt;

    logic               any;
    logic [IDX_W-1:0]   idx;
    logic [NUM_IRQ-1:0] onehot;
    logic               idle;
    logic               start;

    irq_prio_enc u_enc (
        .pend   (PEND),
        .any    (any),
        .idx    (idx),
        .onehot (onehot)
    );

    assign idle  = (state == ST_IDLE);
    assign start = MCYCLE & BOUNDARY & ime_q & any & idle;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ime_nxt    = ime_q;
        ei_nxt     = ei_pend;
        halted_nxt = halted_q;
        bug_nxt    = bug_q;
        vec_nxt    = vec_q;
        sel_nxt    = sel_q;
        if (MCYCLE) begin
            bug_nxt = 1'b0;
            unique case (state)
                ST_IDLE:    if (start) state_nxt = ST_WAIT1;
                ST_WAIT1:   state_nxt = ST_WAIT2;
                ST_WAIT2:   state_nxt = ST_PUSH_HI;
                ST_PUSH_HI: begin
                    state_nxt = ST_PUSH_LO;
                    // a withdrawn request leaves a null vector and no clear
                    vec_nxt = any ? vec_of(idx) : 16'h0000;
                    sel_nxt = onehot;
                end
                ST_PUSH_LO: state_nxt = ST_JUMP;
                ST_JUMP:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
            if (idle) begin
                if (start) begin
                    ime_nxt = 1'b0;
                    ei_nxt  = 1'b0;
                end else if (DI_STB) begin
                    ime_nxt = 1'b0;
                    ei_nxt  = 1'b0;
                end else if (RETI_STB) begin
                    ime_nxt = 1'b1;
                    ei_nxt  = 1'b0;
                end else begin
                    if (ei_pend && BOUNDARY) begin
                        ime_nxt = 1'b1;
                        ei_nxt  = 1'b0;
                    end
                    if (EI_STB && !ime_nxt) ei_nxt = 1'b1;
                end
            end
            if (idle && HALT_STB) begin
                if (!ime_q && any) bug_nxt = 1'b1;
                else halted_nxt = 1'b1;
            end else if (any) begin
                halted_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ime_q    <= 1'b0;
            ei_pend  <= 1'b0;
            halted_q <= 1'b0;
            bug_q    <= 1'b0;
            vec_q    <= 16'h0000;
            sel_q    <= '0;
            BUSY     <= 1'b0;
            PUSH_HI  <= 1'b0;
            PUSH_LO  <= 1'b0;
            LOAD_PC  <= 1'b0;
            IF_CLR   <= '0;
        end else begin
            ime_q    <= ime_nxt;
            ei_pend  <= ei_nxt;
            halted_q <= halted_nxt;
            bug_q    <= bug_nxt;
            vec_q    <= vec_nxt;
            sel_q    <= sel_nxt;
            BUSY     <= (state_nxt != ST_IDLE);
            PUSH_HI  <= (state_nxt == ST_PUSH_HI);
            PUSH_LO  <= (state_nxt == ST_PUSH_LO);
            LOAD_PC  <= (state_nxt == ST_JUMP);
            IF_CLR   <= (state_nxt == ST_JUMP) ? sel_nxt : '0;
        end
    end

    assign IME      = ime_q;
    assign HALTED   = halted_q;
    assign HALT_BUG = bug_q;
    assign VECTOR   = vec_q;

endmodule
